// File: rtl/cla_multiword_seq.sv
// Sequential multi-precision add/subtract built around one 16-bit
// carry-lookahead slice that is reused for NSLICE cycles per operation.

// 16-bit carry-lookahead adder: four 4-bit groups with group generate and
// propagate, plus a second lookahead level across the groups.
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group carries resolved in parallel from group generate/propagate.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;
    assign gg[j]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[j]  = &p[B +: 4];
    assign c[B]   = gc[j];
    assign c[B+1] = g[B] | (p[B] & gc[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[j]);
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

module cla_multiword_seq #(
  parameter int NSLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [16*NSLICE-1:0] a,
  input  logic [16*NSLICE-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*NSLICE-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 16 * NSLICE;
  localparam int IW = $clog2(NSLICE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [IW+3:0] base;
  logic [15:0]   slice_sum;
  logic          slice_cout;
  logic          last;

  // Bit offset of the slice being processed this cycle.
  assign base = {idx_q, 4'b0000};
  assign last = (idx_q == IW'(NSLICE - 1));

  cla_16bit u_cla (
    .a    (a_q[base +: 16]),
    .b    (b_q[base +: 16]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state logic: accept in IDLE, one slice per RUN cycle, hold in DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtract as a + ~b + 1: invert b here, inject the +1 as the first carry.
          a_d     = a;
          b_d     = b ^ {W{op_sub}};
          carry_d = op_sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[base +: 16] = slice_sum;
        carry_d           = slice_cout;
        if (last) begin
          cout_d  = slice_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[15] != a_q[W-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers; everything, including the wide operand
  // registers, is cleared so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: doc/cla_multiword_seq.md
Name: cla_multiword_seq

Overview:
Sequential multi-precision add/subtract unit. It time-shares one 16-bit carry-lookahead adder slice (cla_16bit) across NSLICE cycles to produce a 16*NSLICE-bit result. The adder's carry-out is registered between slices. The block sits between an operand producer and a result consumer and uses valid/ready handshakes on both sides.

Parameters:
NSLICE, 4, number of 16-bit slices; total operand width W = 16*NSLICE; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept an operation
op_sub  input  1  0 = a+b, 1 = a-b
a  input  W  operand A, unsigned or two's complement
b  input  W  operand B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  W  result
cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset value of all outputs is 0. in_ready goes to 1 on the first clock edge after rst_n is released. Internal state is cleared: state = IDLE, slice index = 0, carry register = 0, operand registers = 0.
- Reset asserted mid-operation aborts immediately with no partial result.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on a clock edge with in_valid & in_ready. At accept: register a; register b XOR {W{op_sub}}; carry register <= op_sub; idx <= 0. Go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle the adder computes A[idx], B'[idx] and the carry register. The 16-bit slice result is written to sum[16*idx +: 16]. The carry register takes the slice carry-out. idx increments.
  - When idx == NSLICE-1, the write completes, cout takes that slice's carry-out, and the FSM goes to DONE.
- Latency:
  - Exactly NSLICE RUN cycles.
  - out_valid rises on the NSLICE-th edge after the accept edge.
  - For NSLICE=4: accept at edge t, out_valid high after edge t+4.
- ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the possibly inverted b. It is computed at the final slice.
- DONE:
  - out_valid = 1.
  - sum, cout and ovf stay stable until the handshake completes.
  - On an edge with out_valid & out_ready, go to IDLE. out_valid drops on that edge. sum, cout and ovf keep their last values until the next op overwrites them.
  - in_ready rises on the same edge as the DONE->IDLE transition, so it is first high the cycle after the handshake (no same-cycle turnaround). Minimum issue interval is NSLICE+2 cycles.
- in_valid and operand changes during RUN or DONE are ignored. Operands are sampled only at accept.
- Upper slices of sum keep their previous values until overwritten in RUN. Consumers use sum only while out_valid = 1.
- Width rules:
  - All arithmetic is modulo 2^W.
  - Unsigned interpretation uses cout.
  - Signed interpretation uses ovf.
  - Subtract is implemented as a + ~b + 1, with the +1 injected via the initial carry.

Test Plan:
- Add, NSLICE=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op_sub=0 -> sum=0, cout=1, ovf=0. out_valid rises exactly 4 edges after accept. The carry ripples through all 3 slice boundaries.
- Borrow: a=0, b=1, op_sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
- Signed overflow on add: a=0x7FFF_FFFF_FFFF_FFFF, b=1, op_sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Signed overflow on sub: a=0x8000_0000_0000_0000, b=1, op_sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid. Drive in_valid=1 with new operands throughout.
  - Required: out_valid, sum, cout and ovf are stable; in_ready=0; the second op is not accepted.
  - Then pulse out_ready: in_ready=1 the next cycle, the second op is accepted, and its result is correct.
- Reset mid-RUN: assert rst_n=0 during slice idx=2 -> out_valid, sum, cout, ovf and in_ready go to 0 without waiting for a clock edge. After release, a=0x0000_0001_0000_FFFF + b=0x0000_0000_0000_0001 -> sum=0x0000_0001_0001_0000, cout=0.
